// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and widths for the memory port arbiter.
//   owner_t    : which requester owns the read data returning next cycle
//   STAT_W     : width of the optional statistics counters
//   MEM_DATA_W : memory word width
//   MEM_BE_W   : byte-enable width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_LS   = 2'd2
    } owner_t;

    localparam int STAT_W     = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = 4;

endpackage

// File: rtl/mem_arb_sat_counter.sv
// mem_arb_sat_counter
//   Saturating event counter. It holds at all-ones instead of wrapping.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   inc : count one event this cycle
//   cnt : current count (STAT_W bits)
module mem_arb_sat_counter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + STAT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-ported memory between instruction fetch
//   and the load/store unit. LSU has priority. A fetch request that has
//   lost STARVE_MAX consecutive cycles wins the next one. Read data comes
//   back one cycle after the grant and is steered by a registered owner tag.
//
//   Ports
//     clk, rst                       clock, synchronous active-high reset
//     if_req/if_addr                 fetch read request
//     if_gnt/if_rvalid/if_rdata      fetch grant and read response
//     ls_req/ls_we/ls_be/ls_addr/ls_wdata   LSU request
//     ls_gnt/ls_rvalid/ls_rdata      LSU grant and read response
//     mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory command
//     mem_rdata                      memory read data (one cycle latency)
//
//   Build option MEM_ARB_STATS_EN adds the saturating counters
//   stat_if_grants, stat_ls_grants and stat_conflicts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [MEM_DATA_W-1:0] if_rdata,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [MEM_BE_W-1:0]   ls_be,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [MEM_DATA_W-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [MEM_DATA_W-1:0] ls_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_if_grants,
    output logic [STAT_W-1:0]     stat_ls_grants,
    output logic [STAT_W-1:0]     stat_conflicts
`endif
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    owner_t           resp_owner;
    logic             if_win;
    logic             ls_win;

    // Grants are forced low during reset so nothing reaches memory.
    always_comb begin
        if_win = !rst && if_req && (!ls_req || (starve_cnt == STARVE_LIM));
        ls_win = !rst && ls_req && !if_win;
    end

    assign if_gnt    = if_win;
    assign ls_gnt    = ls_win;

    assign mem_en    = if_win | ls_win;
    assign mem_we    = ls_win & ls_we;
    assign mem_be    = ls_win ? ls_be : '0;
    assign mem_addr  = if_win ? if_addr : ls_addr;
    assign mem_wdata = ls_wdata;

    // Fetch can only be denied while the counter is below the limit, so the
    // increment never runs past STARVE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            resp_owner <= OWNER_NONE;
        end else begin
            if (if_req && !if_win) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end

            if (if_win) begin
                resp_owner <= OWNER_IF;
            end else if (ls_win && !ls_we) begin
                resp_owner <= OWNER_LS;
            end else begin
                resp_owner <= OWNER_NONE;
            end
        end
    end

    // Gating with rst drops a read that was granted just before reset.
    assign if_rvalid = !rst && (resp_owner == OWNER_IF);
    assign ls_rvalid = !rst && (resp_owner == OWNER_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    mem_arb_sat_counter u_stat_if (
        .clk (clk),
        .rst (rst),
        .inc (if_win),
        .cnt (stat_if_grants)
    );

    mem_arb_sat_counter u_stat_ls (
        .clk (clk),
        .rst (rst),
        .inc (ls_win),
        .cnt (stat_ls_grants)
    );

    mem_arb_sat_counter u_stat_conf (
        .clk (clk),
        .rst (rst),
        .inc (if_req && ls_req),
        .cnt (stat_conflicts)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives mem_port_arbiter against a behavioural memory and checks every
//   cycle against a reference model built from the arbitration rules:
//   grant winner, memory command, response timing and returned data.
//   With MEM_ARB_STATS_EN defined the statistics counters are also checked.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 16;
    localparam int STARVE_MAX = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [31:0]        if_rdata;
    logic               ls_req;
    logic               ls_we;
    logic [3:0]         ls_be;
    logic [ADDR_W-1:0]  ls_addr;
    logic [31:0]        ls_wdata;
    logic               ls_gnt;
    logic               ls_rvalid;
    logic [31:0]        ls_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata = 32'h0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]        stat_if_grants;
    logic [31:0]        stat_ls_grants;
    logic [31:0]        stat_conflicts;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_ls_grants (stat_ls_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // Power-up contents of every word, so reads of unwritten words are known.
    function automatic logic [31:0] init_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    // Behavioural synchronous memory.
    logic [31:0] env_mem [0:65535];
    bit          env_wr  [0:65535];
    logic [31:0] env_w;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                env_w = env_wr[mem_addr] ? env_mem[mem_addr] : init_word(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) env_w[8*b +: 8] = mem_wdata[8*b +: 8];
                env_mem[mem_addr] <= env_w;
                env_wr[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : init_word(mem_addr);
            end
        end
    end

    // Reference model state.
    int          n_cmp = 0;
    int          n_err = 0;
    int          losses = 0;           // consecutive cycles fetch asked and lost
    bit          exp_if_rv = 1'b0;
    bit          exp_ls_rv = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] ref_mem [int];
    byte         glog [$];             // observed grants: 0 none, 1 IF, 2 LS

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    // One clock cycle: inputs are already applied; check at the negedge,
    // advance the model, and return just after the next rising edge.
    task automatic step();
        bit          e_if;
        bit          e_ls;
        logic [31:0] w;
        @(negedge clk);
        if (rst) begin
            e_if = 1'b0;
            e_ls = 1'b0;
        end else begin
            e_if = if_req && (!ls_req || losses == STARVE_MAX);
            e_ls = ls_req && !e_if;
        end

        n_cmp++;
        if (if_gnt !== e_if) begin
            n_err++; $display("FAIL if_gnt: got %b want %b at %0t", if_gnt, e_if, $time);
        end
        n_cmp++;
        if (ls_gnt !== e_ls) begin
            n_err++; $display("FAIL ls_gnt: got %b want %b at %0t", ls_gnt, e_ls, $time);
        end
        n_cmp++;
        if (mem_en !== (e_if | e_ls)) begin
            n_err++; $display("FAIL mem_en: got %b want %b at %0t", mem_en, e_if | e_ls, $time);
        end
        if (e_if || e_ls) begin
            n_cmp++;
            if (mem_addr !== (e_if ? if_addr : ls_addr)) begin
                n_err++; $display("FAIL mem_addr: got %h want %h at %0t", mem_addr,
                                  e_if ? if_addr : ls_addr, $time);
            end
            n_cmp++;
            if (mem_we !== (e_ls && ls_we)) begin
                n_err++; $display("FAIL mem_we: got %b want %b at %0t", mem_we, e_ls && ls_we, $time);
            end
        end
        if (e_ls && ls_we) begin
            n_cmp++;
            if (mem_be !== ls_be || mem_wdata !== ls_wdata) begin
                n_err++; $display("FAIL mem_wr: got be=%h data=%h want be=%h data=%h at %0t",
                                  mem_be, mem_wdata, ls_be, ls_wdata, $time);
            end
        end

        n_cmp++;
        if (if_rvalid !== (exp_if_rv && !rst)) begin
            n_err++; $display("FAIL if_rvalid: got %b want %b at %0t", if_rvalid, exp_if_rv && !rst, $time);
        end
        n_cmp++;
        if (ls_rvalid !== (exp_ls_rv && !rst)) begin
            n_err++; $display("FAIL ls_rvalid: got %b want %b at %0t", ls_rvalid, exp_ls_rv && !rst, $time);
        end
        if (exp_if_rv && !rst) begin
            n_cmp++;
            if (if_rdata !== exp_rdata) begin
                n_err++; $display("FAIL if_rdata: got %h want %h at %0t", if_rdata, exp_rdata, $time);
            end
        end
        if (exp_ls_rv && !rst) begin
            n_cmp++;
            if (ls_rdata !== exp_rdata) begin
                n_err++; $display("FAIL ls_rdata: got %h want %h at %0t", ls_rdata, exp_rdata, $time);
            end
        end

        glog.push_back(if_gnt ? 8'sd1 : (ls_gnt ? 8'sd2 : 8'sd0));

        if (rst) begin
            losses    = 0;
            exp_if_rv = 1'b0;
            exp_ls_rv = 1'b0;
        end else begin
            losses    = (if_req && !e_if) ? losses + 1 : 0;
            exp_if_rv = e_if;
            exp_ls_rv = e_ls && !ls_we;
            if (e_if) begin
                exp_rdata = ref_read(if_addr);
            end else if (e_ls && !ls_we) begin
                exp_rdata = ref_read(ls_addr);
            end else if (e_ls) begin
                w = ref_read(ls_addr);
                for (int b = 0; b < 4; b++)
                    if (ls_be[b]) w[8*b +: 8] = ls_wdata[8*b +: 8];
                ref_mem[int'(ls_addr)] = w;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 16'h0004;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 16'h0008; ls_wdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_uncontended_fetch();
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        if_req = 1'b0;
        step();
    endtask

    task automatic test_lsu_write();
        logic [31:0] orig;
        orig = ref_read(16'h0100);
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3; ls_addr = 16'h0100; ls_wdata = 32'hDEADBEEF;
        step();
        ls_req = 1'b0;
        step();
        ls_req = 1'b1; ls_we = 1'b0;
        step();
        ls_req = 1'b0;
        n_cmp++;
        if (ls_rdata !== {orig[31:16], 16'hBEEF}) begin
            n_err++; $display("FAIL lsu_partial_write: got %h want %h", ls_rdata, {orig[31:16], 16'hBEEF});
        end
        step();
    endtask

    // Both requesters held for n cycles; each winner presents a new address.
    task automatic contend(input int n);
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF;
        if_addr = 16'($urandom_range(0, 63));
        ls_addr = 16'($urandom_range(0, 63));
        for (int i = 0; i < n; i++) begin
            step();
            if (glog[glog.size()-1] == 1) if_addr = 16'($urandom_range(0, 63));
            if (glog[glog.size()-1] == 2) ls_addr = 16'($urandom_range(0, 63));
        end
    endtask

    task automatic test_contention();
        idle_inputs();
        step();
        glog.delete();
        contend(10);
        idle_inputs();
        step();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (glog[i] != ((i % (STARVE_MAX + 1)) == STARVE_MAX ? 1 : 2)) begin
                n_err++; $display("FAIL contention_seq[%0d]: got %0d want %0d", i, glog[i],
                                  (i % (STARVE_MAX + 1)) == STARVE_MAX ? 1 : 2);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1; if_addr = 16'h0021;
        step();
        rst = 1'b1; ls_req = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_withdrawal();
        idle_inputs();
        step();
        glog.delete();
        contend(3);
        if_req = 1'b0;
        step();
        if_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (glog[glog.size()-1] == 2) ls_addr = 16'($urandom_range(0, 63));
        end
        idle_inputs();
        step();
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (glog[i] != ((i == 8) ? 1 : 2)) begin
                n_err++; $display("FAIL withdrawal_seq[%0d]: got %0d want %0d", i, glog[i], (i == 8) ? 1 : 2);
            end
        end
    endtask

    task automatic test_random(input int n);
        byte g;
        for (int i = 0; i < n; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step();
            g = glog[glog.size()-1];
            if (g == 1 || !if_req || $urandom_range(0, 9) == 0) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 16'($urandom_range(0, 63));
            end
            if (g == 2 || !ls_req || $urandom_range(0, 9) == 0) begin
                ls_req   = ($urandom_range(0, 2) != 0);
                ls_we    = $urandom_range(0, 1) == 1;
                ls_be    = 4'($urandom);
                ls_addr  = 16'($urandom_range(0, 63));
                ls_wdata = $urandom;
            end
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        glog.delete();
        contend(10);
        idle_inputs();
        step();
        n_cmp++;
        if (stat_ls_grants !== 32'd8 || stat_if_grants !== 32'd2 || stat_conflicts !== 32'd10) begin
            n_err++; $display("FAIL stats: got ls=%0d if=%0d conf=%0d want ls=8 if=2 conf=10",
                              stat_ls_grants, stat_if_grants, stat_conflicts);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        if_addr = '0; ls_addr = '0; ls_be = '0; ls_wdata = '0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_uncontended_fetch();
        test_lsu_write();
        test_contention();
        test_reset_mid_read();
        test_withdrawal();
        test_random(2000);
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
